// File: rtl/blob_labeler.sv
// Raster-scan connected-component labeler: counts blobs above a size threshold; result 4*L+1 cycles after the last pixel.
// No backpressure (i_valid is honoured only in IDLE/SCAN); `define BLOB_CONN8_EN selects 8- instead of 4-connectivity.
module blob_labeler #(
   parameter int IMG_COL   = 640,
   parameter int IMG_ROW   = 480,
   parameter int LABEL_W   = 8,
   parameter int PIX_W     = 15,
   parameter int THR_SHIFT = 3
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_sof,
   input  logic               i_valid,
   input  logic               i_pix,
   output logic               o_busy,
   output logic               o_valid,
   output logic [LABEL_W-1:0] o_count,
   output logic [PIX_W-1:0]   o_max,
   output logic               o_ovf
);

   localparam int NLBL = 1 << LABEL_W;
   localparam int CW   = (IMG_COL > 1) ? $clog2(IMG_COL) : 1;
   localparam int RW   = (IMG_ROW > 1) ? $clog2(IMG_ROW) : 1;
   localparam logic [LABEL_W-1:0] L_MAX    = LABEL_W'(NLBL - 1);
   localparam logic [LABEL_W-1:0] LBL_ONE  = LABEL_W'(1);
   localparam logic [PIX_W-1:0]   PIX_ONE  = PIX_W'(1);
   localparam logic [CW-1:0]      COL_LAST = CW'(IMG_COL - 1);
   localparam logic [RW-1:0]      ROW_LAST = RW'(IMG_ROW - 1);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SCAN    = 3'd1;
   localparam logic [2:0] ST_RESOLVE = 3'd2;
   localparam logic [2:0] ST_MERGE   = 3'd3;
   localparam logic [2:0] ST_FINDMAX = 3'd4;
   localparam logic [2:0] ST_COUNT   = 3'd5;
   localparam logic [2:0] ST_OUTPUT  = 3'd6;

`ifdef BLOB_CONN8_EN
   localparam int NB = 4;
`else
   localparam int NB = 2;
`endif

   logic [2:0]         state_q, state_d;
   logic [CW-1:0]      col_q, col_d;
   logic [RW-1:0]      row_q, row_d;
   logic [LABEL_W-1:0] idx_q, idx_d;
   logic [LABEL_W-1:0] used_q, used_d;
   logic [LABEL_W-1:0] cnt_q, cnt_d;
   logic [PIX_W-1:0]   max_q, max_d;
   logic               ovf_q, ovf_d;
   logic               o_valid_q, o_valid_d;
   logic [LABEL_W-1:0] o_count_q, o_count_d;
   logic [PIX_W-1:0]   o_max_q, o_max_d;
   logic               o_ovf_q, o_ovf_d;

   // lb_q[k] holds the label of the pixel accepted k+1 pixels ago
   logic [LABEL_W-1:0] lb_q   [IMG_COL+1];
   logic [LABEL_W-1:0] lb_d   [IMG_COL+1];
   logic [LABEL_W-1:0] tbl_q  [NLBL];
   logic [LABEL_W-1:0] tbl_d  [NLBL];
   logic [PIX_W-1:0]   size_q [NLBL];
   logic [PIX_W-1:0]   size_d [NLBL];

   logic [LABEL_W-1:0] nb [NB];
   logic [LABEL_W-1:0] rt;
   logic [LABEL_W-1:0] m;
   logic [LABEL_W-1:0] lbl;
   logic [LABEL_W-1:0] new_lbl;
   logic [LABEL_W-1:0] par;
   logic               accept;

   function automatic logic [PIX_W-1:0] sat_add(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
      logic [PIX_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[PIX_W] ? {PIX_W{1'b1}} : s[PIX_W-1:0];
   endfunction

   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      row_d     = row_q;
      idx_d     = idx_q;
      used_d    = used_q;
      cnt_d     = cnt_q;
      max_d     = max_q;
      ovf_d     = ovf_q;
      o_valid_d = 1'b0;
      o_count_d = o_count_q;
      o_max_d   = o_max_q;
      o_ovf_d   = o_ovf_q;
      lb_d      = lb_q;
      tbl_d     = tbl_q;
      size_d    = size_q;
      rt        = '0;
      m         = '0;
      lbl       = '0;
      par       = tbl_q[idx_q];
      new_lbl   = used_q + LBL_ONE;
      accept    = i_valid && ((state_q == ST_IDLE && i_sof) || state_q == ST_SCAN);

      // Neighbours outside the image read as background
      nb[0] = (col_q != '0) ? lb_q[0] : '0;
      nb[1] = (row_q != '0) ? lb_q[IMG_COL-1] : '0;
`ifdef BLOB_CONN8_EN
      nb[2] = (row_q != '0 && col_q != '0) ? lb_q[IMG_COL] : '0;
      nb[3] = (row_q != '0 && col_q != COL_LAST) ? lb_q[IMG_COL-2] : '0;
`endif
      for (int k = 0; k < NB; k++) begin
         rt = tbl_q[nb[k]];
         if (rt != '0 && (m == '0 || rt < m)) m = rt;
      end

      case (state_q)
         ST_IDLE, ST_SCAN: begin
            if (accept) begin
               if (state_q == ST_IDLE) begin
                  ovf_d = 1'b0;
                  cnt_d = '0;
                  max_d = '0;
               end
               if (i_pix) begin
                  if (m != '0) begin
                     lbl       = m;
                     size_d[m] = sat_add(size_q[m], PIX_ONE);
                     for (int k = 0; k < NB; k++) begin
                        rt = tbl_q[nb[k]];
                        if (rt != '0 && rt != m) tbl_d[rt] = m;
                     end
                  end else if (used_q != L_MAX) begin
                     lbl             = new_lbl;
                     tbl_d[new_lbl]  = new_lbl;
                     size_d[new_lbl] = PIX_ONE;
                     used_d          = new_lbl;
                  end else begin
                     ovf_d = 1'b1;
                  end
               end
               lb_d[0] = lbl;
               for (int k = 1; k <= IMG_COL; k++) lb_d[k] = lb_q[k-1];
               state_d = ST_SCAN;
               if (col_q == COL_LAST) begin
                  col_d = '0;
                  if (row_q == ROW_LAST) begin
                     row_d   = '0;
                     idx_d   = LBL_ONE;
                     state_d = ST_RESOLVE;
                  end else begin
                     row_d = row_q + 1'b1;
                  end
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         ST_RESOLVE: begin
            // Parents are always smaller labels, so tbl_q[par] is already flattened
            tbl_d[idx_q] = tbl_q[par];
            if (idx_q == L_MAX) state_d = ST_MERGE;
            else                idx_d   = idx_q + LBL_ONE;
         end
         ST_MERGE: begin
            if (par != idx_q) begin
               size_d[par]   = sat_add(size_q[par], size_q[idx_q]);
               size_d[idx_q] = '0;
            end
            if (idx_q == LBL_ONE) state_d = ST_FINDMAX;
            else                  idx_d   = idx_q - LBL_ONE;
         end
         ST_FINDMAX: begin
            if (size_q[idx_q] > max_q) max_d = size_q[idx_q];
            if (idx_q == L_MAX) begin
               idx_d   = LBL_ONE;
               state_d = ST_COUNT;
            end else begin
               idx_d = idx_q + LBL_ONE;
            end
         end
         ST_COUNT: begin
            if (size_q[idx_q] != '0 && size_q[idx_q] > (max_q >> THR_SHIFT) && cnt_q != L_MAX)
               cnt_d = cnt_q + LBL_ONE;
            size_d[idx_q] = '0;
            tbl_d[idx_q]  = '0;
            used_d        = '0;
            if (idx_q == L_MAX) state_d = ST_OUTPUT;
            else                idx_d   = idx_q + LBL_ONE;
         end
         ST_OUTPUT: begin
            o_valid_d = 1'b1;
            o_count_d = cnt_q;
            o_max_d   = max_q;
            o_ovf_d   = ovf_q;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         col_q     <= '0;
         row_q     <= '0;
         idx_q     <= '0;
         used_q    <= '0;
         cnt_q     <= '0;
         max_q     <= '0;
         ovf_q     <= 1'b0;
         o_valid_q <= 1'b0;
         o_count_q <= '0;
         o_max_q   <= '0;
         o_ovf_q   <= 1'b0;
         lb_q      <= '{default: '0};
         tbl_q     <= '{default: '0};
         size_q    <= '{default: '0};
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         row_q     <= row_d;
         idx_q     <= idx_d;
         used_q    <= used_d;
         cnt_q     <= cnt_d;
         max_q     <= max_d;
         ovf_q     <= ovf_d;
         o_valid_q <= o_valid_d;
         o_count_q <= o_count_d;
         o_max_q   <= o_max_d;
         o_ovf_q   <= o_ovf_d;
         lb_q      <= lb_d;
         tbl_q     <= tbl_d;
         size_q    <= size_d;
      end
   end

   assign o_busy  = (state_q != ST_IDLE);
   assign o_valid = o_valid_q;
   assign o_count = o_count_q;
   assign o_max   = o_max_q;
   assign o_ovf   = o_ovf_q;

endmodule

// File: tb/tb_blob_labeler.sv
// Directed bench for blob_labeler on an 8x4 image: dut (LABEL_W=4, L=15) and dut2 (LABEL_W=2, L=3).
// Frames are 32-bit maps, bit r*8+c is pixel (row r, col c).
module tb_blob_labeler;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        sof, vld, pix, sel;
   logic        v1_in, v2_in;
   logic        busy1, val1, ovf1;
   logic [3:0]  cnt1;
   logic [14:0] max1;
   logic        busy2, val2, ovf2;
   logic [1:0]  cnt2;
   logic [14:0] max2;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          r_lat;
   int          r_cnt;
   int          r_max;
   logic        r_ovf;
   logic        r_busy0;

`ifdef BLOB_CONN8_EN
   localparam int DIAG_CNT = 1;
   localparam int DIAG_MAX = 3;
`else
   localparam int DIAG_CNT = 3;
   localparam int DIAG_MAX = 1;
`endif

   always #5 clk = ~clk;

   assign v1_in = vld & ~sel;
   assign v2_in = vld & sel;

   blob_labeler #(.IMG_COL(8), .IMG_ROW(4), .LABEL_W(4), .PIX_W(15), .THR_SHIFT(3)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_sof(sof), .i_valid(v1_in), .i_pix(pix),
      .o_busy(busy1), .o_valid(val1), .o_count(cnt1), .o_max(max1), .o_ovf(ovf1));

   blob_labeler #(.IMG_COL(8), .IMG_ROW(4), .LABEL_W(2), .PIX_W(15), .THR_SHIFT(3)) dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_sof(sof), .i_valid(v2_in), .i_pix(pix),
      .o_busy(busy2), .o_valid(val2), .o_count(cnt2), .o_max(max2), .o_ovf(ovf2));

   // Drives one frame, then counts cycles from the last accepting edge to o_valid
   task automatic run_frame(input logic [31:0] f, input logic use2, input logic gaps);
      logic seen;
      sel = use2;
      for (int p = 0; p < 32; p++) begin
         if (gaps && (p % 5 == 2)) begin
            @(negedge clk);
            vld = 1'b0; sof = 1'b1; pix = 1'b1;
         end
         @(negedge clk);
         if (p == 1) r_busy0 = use2 ? busy2 : busy1;
         vld = 1'b1;
         sof = (p == 0) || (gaps && p == 9);
         pix = f[p];
      end
      @(posedge clk);
      #1;
      vld = 1'b0; sof = 1'b0; pix = 1'b0;
      r_lat = 0;
      seen  = 1'b0;
      while (!seen && r_lat < 200) begin
         @(posedge clk);
         #1;
         r_lat++;
         seen = use2 ? val2 : val1;
      end
      r_cnt = use2 ? int'(cnt2) : int'(cnt1);
      r_max = use2 ? int'(max2) : int'(max1);
      r_ovf = use2 ? ovf2 : ovf1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; sof = 1'b0; vld = 1'b0; pix = 1'b0; sel = 1'b0;
      #12;
      n_cmp++;
      if ({busy1, val1, cnt1, max1, ovf1} !== 21'd0) begin
         n_bad++; $display("FAIL reset_outputs: got %h want 0", {busy1, val1, cnt1, max1, ovf1});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_idle_ignore();
      sel = 1'b0;
      @(negedge clk);
      vld = 1'b1; sof = 1'b0; pix = 1'b1;
      repeat (5) @(negedge clk);
      n_cmp++;
      if (busy1 !== 1'b0) begin n_bad++; $display("FAIL idle_no_sof_busy: got %b want 0", busy1); end
      vld = 1'b0; pix = 1'b0;
   endtask

   task automatic test_all_zero();
      run_frame(32'h0000_0000, 1'b0, 1'b0);
      n_cmp++;
      if (r_busy0 !== 1'b1) begin n_bad++; $display("FAIL zero_busy_after_sof: got %b want 1", r_busy0); end
      n_cmp++;
      if (r_lat !== 61) begin n_bad++; $display("FAIL zero_latency: got %0d want 61", r_lat); end
      n_cmp++;
      if (r_cnt !== 0 || r_max !== 0 || r_ovf !== 1'b0) begin
         n_bad++; $display("FAIL zero_result: got cnt=%0d max=%0d ovf=%b want 0/0/0", r_cnt, r_max, r_ovf);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (val1 !== 1'b0) begin n_bad++; $display("FAIL zero_valid_one_cycle: got %b want 0", val1); end
      n_cmp++;
      if (busy1 !== 1'b0) begin n_bad++; $display("FAIL zero_busy_after_result: got %b want 0", busy1); end
   endtask

   task automatic test_squares();
      run_frame(32'h6060_0303, 1'b0, 1'b1);
      n_cmp++;
      if (r_lat !== 61) begin n_bad++; $display("FAIL squares_latency: got %0d want 61", r_lat); end
      n_cmp++;
      if (r_cnt !== 2) begin n_bad++; $display("FAIL squares_count: got %0d want 2", r_cnt); end
      n_cmp++;
      if (r_max !== 4) begin n_bad++; $display("FAIL squares_max: got %0d want 4", r_max); end
   endtask

   task automatic test_u_shape();
      run_frame(32'h3E22_2222, 1'b0, 1'b0);
      n_cmp++;
      if (r_cnt !== 1) begin n_bad++; $display("FAIL u_count: got %0d want 1", r_cnt); end
      n_cmp++;
      if (r_max !== 11) begin n_bad++; $display("FAIL u_max: got %0d want 11", r_max); end
   endtask

   // Right arm gets the lower label; lone pixel of size 1 equals max>>3 and is not counted
   task automatic test_merge_threshold();
      run_frame(32'h803E_2220, 1'b0, 1'b0);
      n_cmp++;
      if (r_cnt !== 1) begin n_bad++; $display("FAIL merge_thr_count: got %0d want 1", r_cnt); end
      n_cmp++;
      if (r_max !== 8) begin n_bad++; $display("FAIL merge_thr_max: got %0d want 8", r_max); end
   endtask

   task automatic test_diagonal();
      run_frame(32'h0004_0201, 1'b0, 1'b0);
      n_cmp++;
      if (r_cnt !== DIAG_CNT) begin n_bad++; $display("FAIL diag_count: got %0d want %0d", r_cnt, DIAG_CNT); end
      n_cmp++;
      if (r_max !== DIAG_MAX) begin n_bad++; $display("FAIL diag_max: got %0d want %0d", r_max, DIAG_MAX); end
   endtask

   task automatic test_overflow();
      run_frame(32'h0000_0055, 1'b1, 1'b0);
      n_cmp++;
      if (r_lat !== 13) begin n_bad++; $display("FAIL ovf_latency: got %0d want 13", r_lat); end
      n_cmp++;
      if (r_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", r_ovf); end
      n_cmp++;
      if (r_cnt !== 3) begin n_bad++; $display("FAIL ovf_count: got %0d want 3", r_cnt); end
      n_cmp++;
      if (r_max !== 1) begin n_bad++; $display("FAIL ovf_max: got %0d want 1", r_max); end
      run_frame(32'h0000_0005, 1'b1, 1'b0);
      n_cmp++;
      if (r_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_cleared: got %b want 0", r_ovf); end
      n_cmp++;
      if (r_cnt !== 2) begin n_bad++; $display("FAIL ovf_next_count: got %0d want 2", r_cnt); end
   endtask

   task automatic test_reset_mid_scan();
      sel = 1'b0;
      for (int p = 0; p < 10; p++) begin
         @(negedge clk);
         vld = 1'b1; sof = (p == 0); pix = 1'b1;
      end
      @(negedge clk);
      vld = 1'b0; sof = 1'b0; pix = 1'b0;
      n_cmp++;
      if (busy1 !== 1'b1) begin n_bad++; $display("FAIL midscan_busy_before: got %b want 1", busy1); end
      rst_n = 1'b0;
      #2;
      n_cmp++;
      if ({busy1, val1, cnt1, max1, ovf1} !== 21'd0) begin
         n_bad++; $display("FAIL midscan_reset_outputs: got %h want 0", {busy1, val1, cnt1, max1, ovf1});
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_frame(32'h0F0F_0F4F, 1'b0, 1'b0);
      n_cmp++;
      if (r_lat !== 61) begin n_bad++; $display("FAIL midscan_latency: got %0d want 61", r_lat); end
      n_cmp++;
      if (r_cnt !== 1) begin n_bad++; $display("FAIL midscan_count: got %0d want 1", r_cnt); end
      n_cmp++;
      if (r_max !== 16) begin n_bad++; $display("FAIL midscan_max: got %0d want 16", r_max); end
      n_cmp++;
      if (r_ovf !== 1'b0) begin n_bad++; $display("FAIL midscan_ovf: got %b want 0", r_ovf); end
   endtask

   task automatic test_back_to_back();
      run_frame(32'h6060_0303, 1'b0, 1'b0);
      n_cmp++;
      if (r_cnt !== 2) begin n_bad++; $display("FAIL b2b_count: got %0d want 2", r_cnt); end
      n_cmp++;
      if (r_max !== 4) begin n_bad++; $display("FAIL b2b_max: got %0d want 4", r_max); end
   endtask

   initial begin
      test_reset();
      test_idle_ignore();
      test_all_zero();
      test_squares();
      test_u_shape();
      test_merge_threshold();
      test_diagonal();
      test_overflow();
      test_reset_mid_scan();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
